hall_call_dispatcher: RTL and testbench

// - Registers hall calls (request/request_floor/request_dir) into per-floor up/down pending lamps.
// - Assigns each unassigned call to ELEVATOR_1 or ELEVATOR_2 by travel cost, using a valid/ready offer.
// - Clears a call when the serving car opens its doors at that floor in that direction.
// - Sits between the hall request inputs of top and the two elevator controllers.

---
 rtl/hall_call_dispatcher.sv | 92 +++++++++
 tb/tb_hall_call_dispatcher.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/hall_call_dispatcher.sv
// hall_call_dispatcher: latches hall calls into up/down lamps and offers each unassigned call to the cheaper of two cars
module hall_call_dispatcher #(
  parameter int NUM_FLOORS = 7,
  parameter int PENALTY = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  request,
  input  logic [2:0]            request_floor,
  input  logic                  request_dir,
  input  logic [2:0]            current_floor_elev_1,
  input  logic [2:0]            current_floor_elev_2,
  input  logic                  current_dir_elev_1,
  input  logic                  current_dir_elev_2,
  input  logic [1:0]            state_elev_1,
  input  logic [1:0]            state_elev_2,
  input  logic                  assign_ready_1,
  input  logic                  assign_ready_2,
  output logic                  assign_valid_1,
  output logic                  assign_valid_2,
  output logic [2:0]            assign_floor,
  output logic                  assign_dir,
  output logic [NUM_FLOORS-1:0] hall_up_lamp,
  output logic [NUM_FLOORS-1:0] hall_dn_lamp,
  output logic                  request_ack,
  output logic                  request_err
);
  localparam int E = 2 * NUM_FLOORS;
  localparam logic [3:0] NF = 4'(NUM_FLOORS);
  localparam logic [3:0] LAST = 4'(E - 1);
  localparam logic [4:0] PEN = 5'(PENALTY);
  localparam logic [E-1:0] ONE = E'(1);
  typedef enum logic [1:0] {S_SCAN, S_COST, S_OFFER} state_t;
  state_t state, state_n;
  logic [3:0] ptr, ptr_n, nxt, req_idx, idx_1, idx_2;
  logic tgt, tgt_n, legal, hs, abort, advance, away_1, away_2, entry_dir;
  logic [E-1:0] pending, assigned, set_p, set_a, clr;
  logic [2:0] entry_floor, dist_1, dist_2;
  logic [4:0] cost_1, cost_2;
  always_comb begin
    legal = {1'b0, request_floor} < NF && !(request_dir && {1'b0, request_floor} == NF - 4'd1) && !(!request_dir && request_floor == 3'd0);
    req_idx = request_dir ? {1'b0, request_floor} : NF + {1'b0, request_floor};
    idx_1 = current_dir_elev_1 ? {1'b0, current_floor_elev_1} : NF + {1'b0, current_floor_elev_1};
    idx_2 = current_dir_elev_2 ? {1'b0, current_floor_elev_2} : NF + {1'b0, current_floor_elev_2};
    set_p = request && legal ? ONE << req_idx : '0;
    clr = ((state_elev_1 == 2'd2 && {1'b0, current_floor_elev_1} < NF) ? ONE << idx_1 : '0)
        | ((state_elev_2 == 2'd2 && {1'b0, current_floor_elev_2} < NF) ? ONE << idx_2 : '0);
    entry_dir = ptr < NF;
    entry_floor = entry_dir ? ptr[2:0] : ptr[2:0] - NF[2:0];
    dist_1 = current_floor_elev_1 > entry_floor ? current_floor_elev_1 - entry_floor : entry_floor - current_floor_elev_1;
    dist_2 = current_floor_elev_2 > entry_floor ? current_floor_elev_2 - entry_floor : entry_floor - current_floor_elev_2;
    away_1 = state_elev_1[0] && (current_dir_elev_1 ? entry_floor < current_floor_elev_1 : entry_floor > current_floor_elev_1);
    away_2 = state_elev_2[0] && (current_dir_elev_2 ? entry_floor < current_floor_elev_2 : entry_floor > current_floor_elev_2);
    cost_1 = {2'b0, dist_1} + (away_1 ? PEN : 5'd0);
    cost_2 = {2'b0, dist_2} + (away_2 ? PEN : 5'd0);
    abort = clr[ptr] || !pending[ptr];
    hs = state == S_OFFER && (tgt ? assign_ready_2 : assign_ready_1);
    nxt = ptr == LAST ? 4'd0 : ptr + 4'd1;
    state_n = state == S_SCAN ? (pending[ptr] && !assigned[ptr] ? S_COST : S_SCAN)
            : state == S_COST ? (abort ? S_SCAN : S_OFFER)
            : (hs || abort ? S_SCAN : S_OFFER);
    advance = (state == S_SCAN && !(pending[ptr] && !assigned[ptr])) || (state == S_OFFER && (hs || abort));
    ptr_n = advance ? nxt : ptr;
    tgt_n = state == S_COST ? cost_2 < cost_1 : tgt;
    set_a = hs ? ONE << ptr : '0;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_SCAN;
      ptr <= '0;
      tgt <= 1'b0;
      pending <= '0;
      assigned <= '0;
      request_ack <= 1'b0;
      request_err <= 1'b0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      tgt <= tgt_n;
      pending <= (pending | set_p) & ~clr;
      assigned <= (assigned | set_a) & ~clr & (pending | set_p);
      request_ack <= request && legal;
      request_err <= request && !legal;
    end
  end
  assign assign_valid_1 = state == S_OFFER && !tgt;
  assign assign_valid_2 = state == S_OFFER && tgt;
  assign assign_floor = state == S_OFFER ? entry_floor : 3'd0;
  assign assign_dir = state == S_OFFER && entry_dir;
  assign hall_up_lamp = pending[NUM_FLOORS-1:0];
  assign hall_dn_lamp = pending[E-1:NUM_FLOORS];
endmodule

// File: tb/tb_hall_call_dispatcher.sv
// tb_hall_call_dispatcher: scoreboard bench with a cost-rule reference model for hall_call_dispatcher
module tb_hall_call_dispatcher;
  localparam int N = 7;
  logic clk = 0, reset = 0, request = 0, request_dir = 0;
  logic [2:0] request_floor = 0, current_floor_elev_1 = 0, current_floor_elev_2 = 0;
  logic current_dir_elev_1 = 0, current_dir_elev_2 = 0;
  logic [1:0] state_elev_1 = 0, state_elev_2 = 0;
  logic assign_ready_1 = 0, assign_ready_2 = 0;
  logic assign_valid_1, assign_valid_2, assign_dir, request_ack, request_err;
  logic [2:0] assign_floor;
  logic [N-1:0] hall_up_lamp, hall_dn_lamp;
  int errors = 0, checks = 0;
  bit mp_up[N], mp_dn[N];
  logic [4:0] exp_q[$];
  logic [1:0] prev_v = 0;
  logic [3:0] held = 0;
  always #5 clk = ~clk;
  hall_call_dispatcher #(.NUM_FLOORS(N), .PENALTY(8)) dut (
    .clk(clk), .reset(reset), .request(request), .request_floor(request_floor), .request_dir(request_dir),
    .current_floor_elev_1(current_floor_elev_1), .current_floor_elev_2(current_floor_elev_2),
    .current_dir_elev_1(current_dir_elev_1), .current_dir_elev_2(current_dir_elev_2),
    .state_elev_1(state_elev_1), .state_elev_2(state_elev_2),
    .assign_ready_1(assign_ready_1), .assign_ready_2(assign_ready_2),
    .assign_valid_1(assign_valid_1), .assign_valid_2(assign_valid_2),
    .assign_floor(assign_floor), .assign_dir(assign_dir),
    .hall_up_lamp(hall_up_lamp), .hall_dn_lamp(hall_dn_lamp),
    .request_ack(request_ack), .request_err(request_err)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic int cost(input int cur, input int st, input bit cd, input int f);
    int c;
    c = cur > f ? cur - f : f - cur;
    if ((st == 1 || st == 3) && (cd ? f < cur : f > cur)) c += 8;
    return c;
  endfunction
  function automatic bit is_legal(input int f, input bit d);
    return f < N && !(d && f == N - 1) && !(!d && f == 0);
  endfunction
  function automatic logic [2*N-1:0] lamps();
    logic [2*N-1:0] l;
    l = '0;
    for (int f = 0; f < N; f++) begin
      l[f] = mp_up[f];
      l[N+f] = mp_dn[f];
    end
    return l;
  endfunction
  function automatic void clear_model();
    for (int f = 0; f < N; f++) begin
      mp_up[f] = 0;
      mp_dn[f] = 0;
    end
  endfunction
  always @(negedge clk) begin
    logic [4:0] e;
    if (assign_valid_1 || assign_valid_2) begin
      chk("one_valid", 32'(assign_valid_1 && assign_valid_2), 32'(0));
      if (prev_v == 2'b00) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_offer: got car2=%0d floor %0d dir %0d, expected no offer", assign_valid_2, assign_floor, assign_dir);
        end else begin
          e = exp_q.pop_front();
          chk("offer", 32'({assign_valid_2, assign_floor, assign_dir}), 32'(e));
        end
        held = {assign_floor, assign_dir};
      end else chk("offer_stable", 32'({assign_floor, assign_dir}), 32'(held));
    end
    prev_v = {assign_valid_2, assign_valid_1};
  end
  task automatic set_cars(input int f1, input bit d1, input int s1, input int f2, input bit d2, input int s2);
    current_floor_elev_1 = 3'(f1);
    current_dir_elev_1 = d1;
    state_elev_1 = 2'(s1);
    current_floor_elev_2 = 3'(f2);
    current_dir_elev_2 = d2;
    state_elev_2 = 2'(s2);
  endtask
  task automatic do_req(input int f, input bit d);
    bit legal;
    legal = is_legal(f, d);
    @(posedge clk); #1;
    request = 1;
    request_floor = 3'(f);
    request_dir = d;
    @(posedge clk); #1;
    request = 0;
    @(negedge clk);
    chk("request_ack", 32'(request_ack), 32'(legal));
    chk("request_err", 32'(request_err), 32'(!legal));
    if (legal && !(d ? mp_up[f] : mp_dn[f])) begin
      if (d) mp_up[f] = 1; else mp_dn[f] = 1;
      exp_q.push_back({cost(int'(current_floor_elev_2), int'(state_elev_2), current_dir_elev_2, f)
                       < cost(int'(current_floor_elev_1), int'(state_elev_1), current_dir_elev_1, f), 3'(f), d});
    end
    chk("lamps", 32'({hall_dn_lamp, hall_up_lamp}), 32'(lamps()));
  endtask
  task automatic wait_offer(output bit ok);
    int n;
    n = 0;
    while (!(assign_valid_1 || assign_valid_2) && n < 60) begin
      @(negedge clk);
      n++;
    end
    ok = n < 60;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL offer_timeout: got no offer within 60 cycles, expected one");
    end
  endtask
  task automatic door(input bit car, input int f, input bit d);
    logic [11:0] s;
    s = {current_floor_elev_1, current_dir_elev_1, state_elev_1, current_floor_elev_2, current_dir_elev_2, state_elev_2};
    if (car) begin
      current_floor_elev_2 = 3'(f);
      current_dir_elev_2 = d;
      state_elev_2 = 2'd2;
    end else begin
      current_floor_elev_1 = 3'(f);
      current_dir_elev_1 = d;
      state_elev_1 = 2'd2;
    end
    @(posedge clk); #1;
    {current_floor_elev_1, current_dir_elev_1, state_elev_1, current_floor_elev_2, current_dir_elev_2, state_elev_2} = s;
    if (d) mp_up[f] = 0; else mp_dn[f] = 0;
    @(negedge clk);
    chk("valid_after_clear", 32'({assign_valid_2, assign_valid_1}), 32'(0));
    chk("lamp_clear", 32'({hall_dn_lamp, hall_up_lamp}), 32'(lamps()));
  endtask
  task automatic serve(input int f, input bit d);
    bit ok, car;
    wait_offer(ok);
    if (!ok) return;
    car = assign_valid_2;
    repeat ($urandom_range(3)) @(negedge clk);
    assign_ready_1 = 1;
    assign_ready_2 = 1;
    @(posedge clk); #1;
    assign_ready_1 = 0;
    assign_ready_2 = 0;
    @(negedge clk);
    chk("valid_drop", 32'({assign_valid_2, assign_valid_1}), 32'(0));
    chk("lamp_held", 32'({hall_dn_lamp, hall_up_lamp}), 32'(lamps()));
    door(car, f, d);
  endtask
  initial begin
    #400000;
    $display("FAIL watchdog: got no finish by %0t, expected completion", $time);
    $fatal(1, "watchdog");
  end
  initial begin
    bit ok;
    int f;
    bit d;
    repeat (2) @(negedge clk);
    chk("reset_outputs", 32'({assign_valid_1, assign_valid_2, assign_floor, assign_dir, request_ack, request_err}), 32'(0));
    chk("reset_lamps", 32'({hall_dn_lamp, hall_up_lamp}), 32'(0));
    reset = 1;
    set_cars(0, 0, 0, 5, 0, 0);
    do_req(4, 1);
    chk("lamp_up4", 32'(hall_up_lamp), 32'(7'b0010000));
    serve(4, 1);
    set_cars(3, 1, 1, 6, 0, 0);
    do_req(1, 0);
    serve(1, 0);
    set_cars(2, 0, 0, 2, 0, 0);
    do_req(2, 1);
    serve(2, 1);
    do_req(6, 1);
    do_req(0, 0);
    do_req(7, 1);
    repeat (20) @(negedge clk);
    set_cars(3, 0, 0, 5, 0, 0);
    do_req(3, 1);
    wait_offer(ok);
    if (ok) door(1, 3, 1);
    set_cars(1, 0, 0, 6, 0, 0);
    do_req(5, 0);
    do_req(5, 0);
    serve(5, 0);
    repeat (20) @(negedge clk);
    set_cars(0, 0, 0, 0, 0, 0);
    do_req(2, 0);
    wait_offer(ok);
    reset = 0;
    request = 1;
    request_floor = 3'd4;
    request_dir = 1;
    @(posedge clk); #1;
    request = 0;
    @(negedge clk);
    clear_model();
    chk("reset_mid_valid", 32'({assign_valid_2, assign_valid_1}), 32'(0));
    chk("reset_mid_lamps", 32'({hall_dn_lamp, hall_up_lamp}), 32'(0));
    chk("reset_mid_ack_err", 32'({request_ack, request_err}), 32'(0));
    reset = 1;
    for (int t = 0; t < 30; t++) begin
      f = $urandom_range(7);
      d = 1'($urandom_range(1));
      set_cars($urandom_range(6), 1'($urandom_range(1)), $urandom_range(3), $urandom_range(6), 1'($urandom_range(1)), $urandom_range(3));
      if (state_elev_1 == 2 && int'(current_floor_elev_1) == f && current_dir_elev_1 == d) state_elev_1 = 0;
      if (state_elev_2 == 2 && int'(current_floor_elev_2) == f && current_dir_elev_2 == d) state_elev_2 = 0;
      do_req(f, d);
      if (is_legal(f, d)) serve(f, d);
      else repeat (16) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
